// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef logic [5:0] time_t;

  localparam time_t MAX_VAL = 6'd59;

  // Preset edit step: counts up and wraps past the limit back to zero.
  function automatic time_t wrap_inc(input time_t value, input time_t limit);
    if (value >= limit) begin
      return 6'd0;
    end else begin
      return value + 6'd1;
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider for the countdown tick; tick is high while the count sits at TICK_DIV-1.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_r;

  // Count 0..TICK_DIV-1; clear wins over enable, disabled count holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else if (clr) begin
      count_r <= {CW{1'b0}};
    end else if (en) begin
      if (count_r == LAST) begin
        count_r <= {CW{1'b0}};
      end else begin
        count_r <= count_r + CW'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign tick = (count_r == LAST);

endmodule

// File: rtl/countdown_sequencer.sv
// Mode controller for the mm:ss countdown: preset editing, 1 Hz tick, counter strobes.
// Optional alarm flashing in DONE is enabled with `define ALARM_BLINK_EN.
module countdown_sequencer #(
  parameter int               TICK_DIV = 50000000,
  parameter timer_pkg::time_t MAX_VAL  = timer_pkg::MAX_VAL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       set_mode,
  input  logic       inc_sec,
  input  logic       inc_min,
  input  logic       sec_zero,
  input  logic       min_zero,
  output logic [5:0] preset_sec,
  output logic [5:0] preset_min,
  output logic       load,
  output logic       sec_dec,
  output logic       min_dec,
  output logic       done,
  output logic       blink,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE  = 3'(timer_pkg::ST_IDLE);
  localparam logic [2:0] S_SET   = 3'(timer_pkg::ST_SET);
  localparam logic [2:0] S_RUN   = 3'(timer_pkg::ST_RUN);
  localparam logic [2:0] S_PAUSE = 3'(timer_pkg::ST_PAUSE);
  localparam logic [2:0] S_DONE  = 3'(timer_pkg::ST_DONE);

  logic [2:0]       state_nxt_s;
  timer_pkg::time_t sec_nxt_s;
  timer_pkg::time_t min_nxt_s;
  logic             load_nxt_s;
  logic             sec_dec_nxt_s;
  logic             min_dec_nxt_s;
  logic             pre_en_s;
  logic             pre_clr_s;
  logic             tick_s;
  logic             expired_s;

  assign expired_s = sec_zero && min_zero;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (pre_en_s),
    .clr  (pre_clr_s),
    .tick (tick_s)
  );

  // Next-state, preset edit and strobe decisions.
  always_comb begin
    state_nxt_s   = state;
    sec_nxt_s     = preset_sec;
    min_nxt_s     = preset_min;
    load_nxt_s    = 1'b0;
    sec_dec_nxt_s = 1'b0;
    min_dec_nxt_s = 1'b0;
    pre_en_s      = 1'b0;
    pre_clr_s     = 1'b0;
    case (state)
      S_IDLE: begin
        if (set_mode) begin
          state_nxt_s = S_SET;
        end else if (start_stop && !expired_s) begin
          state_nxt_s = S_RUN;
          pre_clr_s   = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_SET: begin
        if (inc_sec) begin
          sec_nxt_s = timer_pkg::wrap_inc(preset_sec, MAX_VAL);
        end else begin
          sec_nxt_s = preset_sec;
        end
        if (inc_min) begin
          min_nxt_s = timer_pkg::wrap_inc(preset_min, MAX_VAL);
        end else begin
          min_nxt_s = preset_min;
        end
        if (!set_mode) begin
          load_nxt_s  = 1'b1;
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_SET;
        end
      end
      S_RUN: begin
        // A pause landing on the tick lets the count wrap so the tick is not replayed on resume.
        pre_en_s = !start_stop || tick_s;
        if (tick_s && !expired_s) begin
          sec_dec_nxt_s = 1'b1;
          min_dec_nxt_s = sec_zero;
        end else begin
          sec_dec_nxt_s = 1'b0;
          min_dec_nxt_s = 1'b0;
        end
        if (tick_s && expired_s) begin
          state_nxt_s = S_DONE;
        end else if (start_stop) begin
          state_nxt_s = S_PAUSE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      S_PAUSE: begin
        if (set_mode) begin
          state_nxt_s = S_SET;
        end else if (start_stop) begin
          state_nxt_s = S_RUN;
        end else begin
          state_nxt_s = S_PAUSE;
        end
      end
      S_DONE: begin
        pre_en_s = 1'b1;
        if (set_mode) begin
          state_nxt_s = S_SET;
        end else if (start_stop) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, presets and registered strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      preset_sec <= 6'd0;
      preset_min <= 6'd0;
      load       <= 1'b0;
      sec_dec    <= 1'b0;
      min_dec    <= 1'b0;
    end else begin
      state      <= state_nxt_s;
      preset_sec <= sec_nxt_s;
      preset_min <= min_nxt_s;
      load       <= load_nxt_s;
      sec_dec    <= sec_dec_nxt_s;
      min_dec    <= min_dec_nxt_s;
    end
  end

  assign done = (state == S_DONE);

`ifdef ALARM_BLINK_EN
  // Alarm flash: lit on DONE entry, toggled on each tick while DONE holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink <= 1'b0;
    end else if (state_nxt_s == S_DONE) begin
      if (state != S_DONE) begin
        blink <= 1'b1;
      end else if (tick_s) begin
        blink <= ~blink;
      end else begin
        blink <= blink;
      end
    end else begin
      blink <= 1'b0;
    end
  end
`else
  assign blink = done;
`endif

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer with behavioural seconds/minutes counters, TICK_DIV=4.
module tb_countdown_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_sec = 1'b0;
  logic       inc_min = 1'b0;
  logic       sec_zero, min_zero;
  logic [5:0] preset_sec, preset_min;
  logic       load, sec_dec, min_dec, done, blink;
  logic [2:0] state;
  logic [5:0] sec_cnt, min_cnt;
  logic       done_prev = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] kind;
  } ev_t;

  localparam logic [3:0] K_LOAD = 4'b0001;
  localparam logic [3:0] K_SEC  = 4'b0010;
  localparam logic [3:0] K_MIN  = 4'b0100;
  localparam logic [3:0] K_DONE = 4'b1000;

  ev_t exp_q[$];
  ev_t obs_q[$];

  countdown_sequencer #(
    .TICK_DIV(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .set_mode  (set_mode),
    .inc_sec   (inc_sec),
    .inc_min   (inc_min),
    .sec_zero  (sec_zero),
    .min_zero  (min_zero),
    .preset_sec(preset_sec),
    .preset_min(preset_min),
    .load      (load),
    .sec_dec   (sec_dec),
    .min_dec   (min_dec),
    .done      (done),
    .blink     (blink),
    .state     (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural counters: load takes presets, decrement wraps 0 -> 59.
  always @(posedge clk) begin
    if (reset) begin
      sec_cnt <= 6'd0;
      min_cnt <= 6'd0;
    end else if (load) begin
      sec_cnt <= preset_sec;
      min_cnt <= preset_min;
    end else begin
      if (sec_dec) sec_cnt <= (sec_cnt == 6'd0) ? 6'd59 : sec_cnt - 6'd1;
      if (min_dec) min_cnt <= (min_cnt == 6'd0) ? 6'd59 : min_cnt - 6'd1;
    end
  end
  assign sec_zero = (sec_cnt == 6'd0);
  assign min_zero = (min_cnt == 6'd0);

  always @(negedge clk) begin
    if (load || sec_dec || min_dec || (done && !done_prev))
      obs_q.push_back('{cyc, {done && !done_prev, min_dec, sec_dec, load}});
    done_prev <= done;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic load_preset(input int ns, input int nm);
    set_mode = 1'b1;
    step(1);
    for (int i = 0; i < ns; i++) begin
      inc_sec = 1'b1;
      step(1);
      inc_sec = 1'b0;
    end
    for (int i = 0; i < nm; i++) begin
      inc_min = 1'b1;
      step(1);
      inc_min = 1'b0;
    end
    set_mode = 1'b0;
    step(2);
  endtask

  task automatic test_reset();
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++;
    if ({preset_min, preset_sec} !== 12'd0) begin
      failures++; $display("FAIL rst_presets got=%0d:%0d exp=0:0", preset_min, preset_sec);
    end
    checks++;
    if ({load, sec_dec, min_dec, done, blink} !== 5'd0) begin
      failures++; $display("FAIL rst_outputs got=%b exp=00000", {load, sec_dec, min_dec, done, blink});
    end
    load_preset(5, 0);
    pulse_start();
    step(5);
    checks++;
    if (state !== 3'd2) begin failures++; $display("FAIL midrun_state got=%0d exp=2", state); end
    reset = 1'b1;
    step(1);
    checks++;
    if (state !== 3'd0 || {preset_min, preset_sec} !== 12'd0) begin
      failures++; $display("FAIL midrun_abort state=%0d presets=%0d:%0d exp 0 0:0", state, preset_min, preset_sec);
    end
    checks++;
    if ({load, sec_dec, min_dec, done} !== 4'd0) begin
      failures++; $display("FAIL midrun_outputs got=%b exp=0000", {load, sec_dec, min_dec, done});
    end
    reset = 1'b0;
    step(1);
  endtask

  task automatic test_set_edit();
    ev_t e, o;
    int  l;
    do_reset();
    set_mode = 1'b1;
    step(1);
    checks++;
    if (state !== 3'd1) begin failures++; $display("FAIL set_enter got=%0d exp=1", state); end
    for (int i = 0; i < 61; i++) begin
      inc_sec = 1'b1; step(1); inc_sec = 1'b0;
    end
    checks++;
    if (preset_sec !== 6'd1) begin failures++; $display("FAIL set_sec_wrap got=%0d exp=1", preset_sec); end
    for (int i = 0; i < 3; i++) begin
      inc_min = 1'b1; step(1); inc_min = 1'b0;
    end
    checks++;
    if (preset_min !== 6'd3) begin failures++; $display("FAIL set_min got=%0d exp=3", preset_min); end
    inc_sec = 1'b1; inc_min = 1'b1; step(1); inc_sec = 1'b0; inc_min = 1'b0;
    checks++;
    if ({preset_min, preset_sec} !== {6'd4, 6'd2}) begin
      failures++; $display("FAIL set_both got=%0d:%0d exp=4:2", preset_min, preset_sec);
    end
    exp_q.delete(); obs_q.delete();
    l = cyc + 1;
    exp_q.push_back('{l, K_LOAD});
    set_mode = 1'b0;
    step(1);
    checks++;
    if (load !== 1'b1 || state !== 3'd0) begin
      failures++; $display("FAIL set_exit load=%b state=%0d exp load=1 state=0", load, state);
    end
    step(2);
    checks++;
    if ({min_cnt, sec_cnt} !== {6'd4, 6'd2}) begin
      failures++; $display("FAIL set_loaded got=%0d:%0d exp=4:2", min_cnt, sec_cnt);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL set_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc || o.kind !== e.kind) begin
        failures++; $display("FAIL set_event got=%0d/%b exp=%0d/%b", o.cyc, o.kind, e.cyc, e.kind);
      end
    end
  endtask

  task automatic test_countdown();
    ev_t e, o;
    int  st;
    do_reset();
    load_preset(2, 0);
    exp_q.delete(); obs_q.delete();
    st = cyc + 1;
    exp_q.push_back('{st + 4, K_SEC});
    exp_q.push_back('{st + 8, K_SEC});
    exp_q.push_back('{st + 12, K_DONE});
    pulse_start();
    for (int i = 0; i < 40 && done !== 1'b1; i++) step(1);
    checks++;
    if (done !== 1'b1 || cyc != st + 12) begin
      failures++; $display("FAIL cd_done done=%b cycles=%0d exp done=1 cycles=12", done, cyc - st);
    end
    checks++;
    if (blink !== 1'b1) begin failures++; $display("FAIL cd_blink_entry got=%b exp=1", blink); end
    step(4);
`ifdef ALARM_BLINK_EN
    checks++;
    if (blink !== 1'b0) begin failures++; $display("FAIL cd_blink_t1 got=%b exp=0", blink); end
    step(4);
    checks++;
    if (blink !== 1'b1) begin failures++; $display("FAIL cd_blink_t2 got=%b exp=1", blink); end
`else
    checks++;
    if (blink !== 1'b1) begin failures++; $display("FAIL cd_blink_done got=%b exp=1", blink); end
`endif
    pulse_start();
    checks++;
    if (state !== 3'd0 || done !== 1'b0 || blink !== 1'b0) begin
      failures++; $display("FAIL cd_ack state=%0d done=%b blink=%b exp 0 0 0", state, done, blink);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL cd_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc || o.kind !== e.kind) begin
        failures++; $display("FAIL cd_event got=%0d/%b exp=%0d/%b", o.cyc - st, o.kind, e.cyc - st, e.kind);
      end
    end
  endtask

  task automatic test_min_cascade();
    ev_t e, o;
    int  st;
    do_reset();
    load_preset(0, 1);
    exp_q.delete(); obs_q.delete();
    st = cyc + 1;
    exp_q.push_back('{st + 4, K_SEC | K_MIN});
    exp_q.push_back('{st + 8, K_SEC});
    pulse_start();
    step(5);
    checks++;
    if ({min_cnt, sec_cnt} !== {6'd0, 6'd59}) begin
      failures++; $display("FAIL casc_counters got=%0d:%0d exp=0:59", min_cnt, sec_cnt);
    end
    step(4);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL casc_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc || o.kind !== e.kind) begin
        failures++; $display("FAIL casc_event got=%0d/%b exp=%0d/%b", o.cyc - st, o.kind, e.cyc - st, e.kind);
      end
    end
  endtask

  task automatic test_pause_resume();
    ev_t e, o;
    int  r;
    do_reset();
    load_preset(30, 0);
    exp_q.delete(); obs_q.delete();
    pulse_start();
    step(2);
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    checks++;
    if (state !== 3'd3) begin failures++; $display("FAIL pause_enter got=%0d exp=3", state); end
    step(20);
    checks++;
    if (state !== 3'd3) begin failures++; $display("FAIL pause_hold got=%0d exp=3", state); end
    r = cyc + 1;
    exp_q.push_back('{r + 2, K_SEC});
    pulse_start();
    checks++;
    if (state !== 3'd2) begin failures++; $display("FAIL pause_resume got=%0d exp=2", state); end
    step(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL pause_events got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc || o.kind !== e.kind) begin
        failures++; $display("FAIL pause_event got=%0d/%b exp=%0d/%b", o.cyc - r, o.kind, e.cyc - r, e.kind);
      end
    end
    set_mode = 1'b1;
    step(1);
    set_mode = 1'b0;
    checks++;
    if (state !== 3'd2) begin failures++; $display("FAIL run_ignores_set got=%0d exp=2", state); end
  endtask

  task automatic test_idle_zero();
    do_reset();
    exp_q.delete(); obs_q.delete();
    pulse_start();
    step(3);
    checks++;
    if (state !== 3'd0) begin failures++; $display("FAIL idle_zero_state got=%0d exp=0", state); end
    checks++;
    if (obs_q.size() != 0) begin failures++; $display("FAIL idle_zero_events got=%0d exp=0", obs_q.size()); end
  endtask

  task automatic test_done_priority();
    do_reset();
    load_preset(1, 0);
    pulse_start();
    for (int i = 0; i < 30 && done !== 1'b1; i++) step(1);
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL prio_reach_done got=%b exp=1", done); end
    set_mode = 1'b1;
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    checks++;
    if (state !== 3'd1 || done !== 1'b0 || blink !== 1'b0) begin
      failures++; $display("FAIL prio_set_wins state=%0d done=%b blink=%b exp 1 0 0", state, done, blink);
    end
    set_mode = 1'b0;
    step(1);
    checks++;
    if (load !== 1'b1 || state !== 3'd0) begin
      failures++; $display("FAIL prio_exit load=%b state=%0d exp load=1 state=0", load, state);
    end
  endtask

  initial begin
    step(3);
    reset = 1'b0;
    test_reset();
    test_set_edit();
    test_countdown();
    test_min_cascade();
    test_pause_resume();
    test_idle_zero();
    test_done_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/countdown_sequencer.md
Name: countdown_sequencer

Overview:
- Controller for the 6-bit mm:ss countdown counters in the VGA timer display.
- Owns the operating mode: idle, set, run, pause, done.
- Edits and holds the preset minutes/seconds, and generates the 1 Hz tick.
- Issues single-cycle load/decrement strobes to the seconds and minutes counter datapaths, using their zero flags to cascade and to detect expiry.

Parameters:
- TICK_DIV, 50000000, clk cycles per tick (minimum 4).
- MAX_VAL, 59, wrap limit for preset fields and counters.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start_stop  in  1  one-cycle pulse: start/pause/resume/acknowledge
- set_mode  in  1  level; high = edit presets
- inc_sec  in  1  one-cycle pulse: preset_sec +1 (SET only)
- inc_min  in  1  one-cycle pulse: preset_min +1 (SET only)
- sec_zero  in  1  seconds counter == 0
- min_zero  in  1  minutes counter == 0
- preset_sec  out  6  preset seconds value
- preset_min  out  6  preset minutes value
- load  out  1  one-cycle strobe: counters take preset values
- sec_dec  out  1  one-cycle decrement strobe, seconds counter (wraps 0->59 itself)
- min_dec  out  1  one-cycle decrement strobe, minutes counter
- done  out  1  high while in DONE
- blink  out  1  alarm indicator
- state  out  3  current FSM state, for display

Behaviour:
- Reset (synchronous, active-high) values:
  - state = IDLE; preset_sec = preset_min = 0; prescaler = 0.
  - load, sec_dec, min_dec, done, blink all 0.
  - Reset mid-operation aborts immediately; takes priority over all other inputs.
- States: IDLE, SET, RUN, PAUSE, DONE.
- Input priority in any state: reset > set_mode > start_stop. Inputs not listed for a state are ignored.
- IDLE:
  - set_mode=1 -> SET.
  - start_stop with !(sec_zero && min_zero) -> RUN, prescaler cleared.
  - start_stop with both zero flags high -> stay IDLE.
- SET:
  - inc_sec: preset_sec +1, MAX_VAL -> 0.
  - inc_min: preset_min +1, MAX_VAL -> 0.
  - inc_sec and inc_min in the same cycle: both apply.
  - set_mode sampled 0 -> load=1 for exactly that cycle, next state IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; the tick is the cycle the count equals TICK_DIV-1.
  - On tick, evaluated on the registered zero flags:
    - sec_zero && min_zero -> DONE, no strobes.
    - sec_zero only -> sec_dec=1 and min_dec=1 in the same cycle.
    - otherwise -> sec_dec=1 only.
  - start_stop -> PAUSE, prescaler value held. If start_stop coincides with a tick, the tick's strobes still issue.
  - set_mode ignored in RUN.
- PAUSE: prescaler frozen; start_stop -> RUN and prescaler resumes; set_mode -> SET.
- DONE: done=1; start_stop -> IDLE; set_mode -> SET. Prescaler keeps running (used by blink).
- Timing rules:
  - Strobe outputs are registered: asserted the cycle after the decision, width exactly 1 cycle.
  - Counters update one cycle after a strobe. TICK_DIV >= 4 guarantees the zero flags are settled before the next tick.
  - Total countdown from mm:ss, starting at the RUN entry cycle, is (60*mm + ss + 1) ticks until DONE.

Optional Feature:
- Macro: ALARM_BLINK_EN.
- Defined: in DONE, blink toggles on every prescaler tick (starting at 1 on DONE entry); blink = 0 outside DONE.
- Undefined: blink = done combinationally; no extra flop.

Decomposition:
- Shared package timer_pkg holds:
  - state enum (IDLE=0, SET=1, RUN=2, PAUSE=3, DONE=4);
  - MAX_VAL constant 6'd59;
  - 6-bit time field typedef.
- One sub-module, tick_prescaler: TICK_DIV parameter; en, clr inputs; tick output.

Test Plan (TICK_DIV=4, counter behavioural models attached):
- Reset mid-RUN -> next cycle state=IDLE, presets 0, all strobes 0, done=0.
- SET, inc_sec x61 -> preset_sec=1; inc_min x3 -> preset_min=3; set_mode low -> load high exactly 1 cycle, state=IDLE.
- Preset 00:02, start -> sec_dec at ticks 1 and 2; tick 3 -> done=1; total 12 cycles from the RUN entry cycle.
- Preset 01:00, start -> first tick issues sec_dec and min_dec together; counters read 00:59.
- RUN, start_stop at prescaler=2 -> PAUSE, no strobes for 20 cycles; resume -> next tick after 1 more cycle.
- IDLE with 00:00, start -> stays IDLE. DONE with set_mode and start_stop in the same cycle -> SET wins. Under ALARM_BLINK_EN, blink toggles every 4 cycles in DONE.
